// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory responder: data width, default address
// width and the responder's FSM state encoding.
package cpu_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM: write-enabled store, registered read of the
// addressed word every cycle. Contents are never reset.
module ram_array #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read (read returns the pre-write word).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Memory responder for the datapath: accepts rising-edge Read/Write requests,
// optionally waits WAIT_STATES cycles, performs one RAM access, then pulses
// Done. Simultaneous Read and Write edges are rejected with an Err pulse.
module ram_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MARout,
    input  logic [DATA_W-1:0] MDRdata,
    output logic [DATA_W-1:0] RAMout,
    output logic              Done,
    output logic              Busy,
    output logic              Err
);

    // Value loaded into the wait down-counter; WAIT exits when it reaches zero.
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e              state_q, state_d;
    logic [2:0]          wait_cnt_q, wait_cnt_d;
    logic                rd_prev_q, wr_prev_q;
    // Edge history only becomes meaningful one cycle after reset, so a request
    // held high through reset release is not mistaken for a fresh edge.
    logic                hist_vld_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                is_wr_q, is_wr_d;
    logic [DATA_W-1:0]   ramout_q, ramout_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                rd_rise_s, wr_rise_s;
    logic                ram_we_s;
    logic [DATA_W-1:0]   ram_rdata_s;

    assign rd_rise_s = hist_vld_q & Read  & ~rd_prev_q;
    assign wr_rise_s = hist_vld_q & Write & ~wr_prev_q;

    // Gate the write with clear so an access coinciding with reset is dropped.
    assign ram_we_s = (state_q == ST_ACCESS) & is_wr_q & clear;

    ram_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (ram_we_s),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata_s)
    );

    // Next-state, request capture and registered-output next values.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        err_d      = 1'b0;
        busy_d     = (state_q != ST_IDLE);
        done_d     = (state_q == ST_DONE);
        if ((state_q == ST_DONE) && !is_wr_q) begin
            ramout_d = ram_rdata_s;
        end else begin
            ramout_d = ramout_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_rise_s && wr_rise_s) begin
                    err_d = 1'b1;
                end else if (rd_rise_s || wr_rise_s) begin
                    addr_d     = MARout;
                    wdata_d    = MDRdata;
                    is_wr_d    = wr_rise_s;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, history and output registers with synchronous active-low clear.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
            rd_prev_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
            hist_vld_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            ramout_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_prev_q  <= Read;
            wr_prev_q  <= Write;
            hist_vld_q <= 1'b1;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            ramout_q   <= ramout_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign RAMout = ramout_q;
    assign Done   = done_q;
    assign Busy   = busy_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: instance 0 uses WAIT_STATES=1,
// instance 1 uses WAIT_STATES=0. Stimulus pushes expected Done/Err events;
// a negedge monitor pops and compares them.
module tb_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        clr    [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [8:0]  mar    [2];
    logic [31:0] mdr    [2];
    logic [31:0] ramout [2];
    logic        done   [2];
    logic        busy   [2];
    logic        err    [2];

    ram_responder #(.WAIT_STATES(1)) dut0 (
        .Clock(clk), .clear(clr[0]), .Read(rd[0]), .Write(wr[0]),
        .MARout(mar[0]), .MDRdata(mdr[0]), .RAMout(ramout[0]),
        .Done(done[0]), .Busy(busy[0]), .Err(err[0])
    );

    ram_responder #(.WAIT_STATES(0)) dut1 (
        .Clock(clk), .clear(clr[1]), .Read(rd[1]), .Write(wr[1]),
        .MARout(mar[1]), .MDRdata(mdr[1]), .RAMout(ramout[1]),
        .Done(done[1]), .Busy(busy[1]), .Err(err[1])
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    int          eq0 [$];
    int          eq1 [$];
    logic [31:0] model [2][512];
    logic [31:0] last  [2];

    int checks = 0;
    int errors = 0;

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Record the expected outcome of a request issued at this negedge.
    task automatic push_exp(input int i, input bit r, input bit w,
                            input logic [8:0] a, input logic [31:0] d);
        exp_t e;
        if (r && w) begin
            if (i == 0) eq0.push_back(cyc + 1);
            else        eq1.push_back(cyc + 1);
        end else begin
            if (w) model[i][a] = d;
            else   last[i] = model[i][a];
            e.data = last[i];
            e.cyc  = cyc + 3 + ws_of(i);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Drive one request for 'hold' cycles, scramble address/data afterwards,
    // and check the Busy length and the held RAMout value.
    task automatic req(input int i, input bit r, input bit w,
                       input logic [8:0] a, input logic [31:0] d, input int hold);
        int bc = 0;
        push_exp(i, r, w, a, d);
        rd[i] = r; wr[i] = w; mar[i] = a; mdr[i] = d;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (busy[i] === 1'b1) bc++;
        end
        rd[i] = 1'b0; wr[i] = 1'b0; mar[i] = ~a; mdr[i] = ~d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy[i] === 1'b1) bc++;
        end
        chk("busy_cycles", 32'(bc), (r && w) ? 32'd0 : 32'(ws_of(i) + 2));
        chk("ramout_held", ramout[i], last[i]);
    endtask

    // Monitor: compare every Done/Err pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   ec;
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) begin
                if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done inst %0d @cyc %0d: got Done=1 expected Done=0", i, cyc);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk("done_data", ramout[i], e.data);
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (err[i] === 1'b1) begin
                if ((i == 0) ? (eq0.size() == 0) : (eq1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err inst %0d @cyc %0d: got Err=1 expected Err=0", i, cyc);
                end else begin
                    ec = (i == 0) ? eq0.pop_front() : eq1.pop_front();
                    chk("err_cycle", 32'(cyc), 32'(ec));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
            mar[i] = 9'h000; mdr[i] = 32'h0; last[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ramout", ramout[i], 32'h0);
            chk("rst_done", {31'h0, done[i]}, 32'h0);
            chk("rst_busy", {31'h0, busy[i]}, 32'h0);
            chk("rst_err", {31'h0, err[i]}, 32'h0);
        end
        clr[0] = 1'b1; clr[1] = 1'b1;
        @(negedge clk);

        // WAIT_STATES=1: write/read, read-after-write, rejected request
        req(0, 1'b0, 1'b1, 9'h055, 32'h0000_00A5, 1);
        req(0, 1'b1, 1'b0, 9'h055, 32'h0, 1);
        req(0, 1'b0, 1'b1, 9'h0AA, 32'h1234_5678, 1);
        req(0, 1'b1, 1'b0, 9'h0AA, 32'h0, 1);
        req(0, 1'b1, 1'b1, 9'h0AA, 32'hDEAD_BEEF, 1);
        req(0, 1'b1, 1'b0, 9'h0AA, 32'h0, 1);
        // Read level held for three cycles: one transaction only
        req(0, 1'b1, 1'b0, 9'h055, 32'h0, 3);

        // A Write edge while busy must be ignored
        push_exp(0, 1'b1, 1'b0, 9'h055, 32'h0);
        rd[0] = 1'b1; mar[0] = 9'h055;
        @(negedge clk);
        rd[0] = 1'b0; mar[0] = 9'h1AA;
        @(negedge clk);
        wr[0] = 1'b1; mar[0] = 9'h055; mdr[0] = 32'h0000_0BAD;
        @(negedge clk);
        wr[0] = 1'b0;
        repeat (6) @(negedge clk);
        req(0, 1'b1, 1'b0, 9'h055, 32'h0, 1);

        // Clear during WAIT of a write abandons it; held Write needs a new edge
        req(0, 1'b0, 1'b1, 9'h010, 32'h1111_1111, 1);
        wr[0] = 1'b1; mar[0] = 9'h010; mdr[0] = 32'h2222_2222;
        @(negedge clk);
        clr[0] = 1'b0; mar[0] = 9'h1EF; mdr[0] = 32'hDDDD_DDDD;
        @(negedge clk);
        chk("clr_ramout", ramout[0], 32'h0);
        chk("clr_done", {31'h0, done[0]}, 32'h0);
        chk("clr_busy", {31'h0, busy[0]}, 32'h0);
        chk("clr_err", {31'h0, err[0]}, 32'h0);
        last[0] = 32'h0;
        clr[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("held_through_clr_busy", {31'h0, busy[0]}, 32'h0);
        wr[0] = 1'b0;
        repeat (2) @(negedge clk);
        req(0, 1'b1, 1'b0, 9'h010, 32'h0, 1);
        req(0, 1'b1, 1'b0, 9'h055, 32'h0, 1);

        // WAIT_STATES=0: top address, another address, and a rejected request
        req(1, 1'b0, 1'b1, 9'h1FF, 32'hFFFF_FFFF, 1);
        req(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 1);
        req(1, 1'b0, 1'b1, 9'h000, 32'h0F0F_0F0F, 1);
        req(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 1);
        req(1, 1'b1, 1'b1, 9'h1FF, 32'h0, 1);
        req(1, 1'b1, 1'b0, 9'h000, 32'h0, 1);

        repeat (4) @(negedge clk);
        chk("pending_done_inst0", 32'(q0.size()), 32'd0);
        chk("pending_done_inst1", 32'(q1.size()), 32'd0);
        chk("pending_err_inst0", 32'(eq0.size()), 32'd0);
        chk("pending_err_inst1", 32'(eq1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH, default 512: number of 32-bit words in memory.
REQ-002 Parameter ADDR_W, default 9: address width, equal to log2(DEPTH).
REQ-003 Parameter WAIT_STATES, default 1: idle cycles between request accept and access, legal range 0..7.
REQ-004 Port Clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port clear, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port Read, input, 1 bit: read request from the datapath control sequence.
REQ-007 Port Write, input, 1 bit: write request from the datapath control sequence.
REQ-008 Port MARout, input, ADDR_W bits: word address, taken from the low bits of MAR.
REQ-009 Port MDRdata, input, 32 bits: write data, taken from MDR.
REQ-010 Port RAMout, output, 32 bits: read data, feeds BusMuxInRamout and the MDR read path.
REQ-011 Port Done, output, 1 bit: one-cycle completion pulse.
REQ-012 Port Busy, output, 1 bit: high from the cycle after accept until the Done cycle inclusive.
REQ-013 Port Err, output, 1 bit: one-cycle pulse on an illegal request.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT, ACCESS and DONE.
REQ-015 In IDLE, a rising edge on Read or Write (low in the previous cycle, high now) SHALL be accepted, and MARout and MDRdata SHALL be captured at that same edge.
REQ-016 A level held high on Read or Write SHALL NOT be re-accepted; each new request SHALL require a low-to-high transition.
REQ-017 When Read and Write both rise in the same cycle, the request SHALL be rejected: Err pulses for one cycle, memory and RAMout are unchanged, and the FSM stays in IDLE.
REQ-018 From IDLE on accept, the FSM SHALL go to WAIT when WAIT_STATES>0 and directly to ACCESS when WAIT_STATES=0.
REQ-019 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 3-bit down-counter, then move to ACCESS.
REQ-020 In ACCESS, a write SHALL store the captured data at the captured address; a read SHALL load RAMout from the captured address.
REQ-021 DONE SHALL assert Done for exactly one cycle and then return to IDLE.
REQ-022 RAMout SHALL update only in ACCESS for a read and SHALL hold its value otherwise, including across writes.
REQ-023 Latency from the accept edge to Done high SHALL be WAIT_STATES+2 cycles.
REQ-024 Rising edges on Read or Write outside IDLE SHALL be ignored, with no Err and no queuing.
REQ-025 Changes on MARout or MDRdata after accept SHALL NOT affect the transaction in flight.
REQ-026 Addresses SHALL index modulo DEPTH, so the top address wraps with no error.
REQ-027 A read of a location written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-028 While clear=0 at a rising edge, the FSM SHALL go to IDLE, RAMout SHALL be 0, Done, Busy and Err SHALL be 0, the wait counter and edge-detect history SHALL be 0, and any in-flight transaction SHALL be abandoned with no memory write.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A request held high through the release of clear SHALL be accepted only after a fresh rising edge.

Structure
REQ-031 The FSM state enum, DATA_W=32 and the default ADDR_W SHALL reside in shared package cpu_mem_pkg.
REQ-032 Storage SHALL be a sub-module ram_array: a single-port synchronous RAM with write enable, no reset, and registered read.
REQ-033 The FSM, edge detect, wait counter and output registers SHALL reside in ram_responder.

Verification
REQ-034 Write 0x0000_00A5 to address 0x055 with WAIT_STATES=1 -> Busy high for 3 cycles, Done pulses 3 cycles after the accept edge, RAMout unchanged.
REQ-035 Read of address 0x055 after that write -> RAMout=0x0000_00A5 in the Done cycle, and the value is held afterwards.
REQ-036 Read and Write rising in the same cycle -> Err pulses one cycle, no Done, and a subsequent read of the target address returns its old value.
REQ-037 Read held high for 3 cycles -> exactly one Done; a second Read edge while Busy -> ignored.
REQ-038 clear driven low during WAIT of a write to 0x010 -> outputs go to 0 next edge, and a later read of 0x010 returns its pre-write value.
REQ-039 WAIT_STATES=0, write 0xFFFF_FFFF to address 0x1FF, then read it -> Done 2 cycles after each accept, and RAMout=0xFFFF_FFFF.
